tx_line_framer: RTL and testbench
=================================

Name: tx_line_framer

Overview:
- Sits directly upstream of the UART transmit interface, between the RAM read-out stream and the `uart` tx side.
- Passes payload bytes through unchanged and inserts an end-of-line sequence:
  - after every LINE_LEN payload bytes, and
  - after the byte flagged as last in a block.
- Output is fully registered with valid/ready handshakes on both sides, so the echo path produces terminal-readable lines.

Parameters:
- LINE_LEN, 16, payload bytes per line before an automatic EOL; legal range 1..255.
- EOL_CRLF, 1, 1 = EOL is CR (8'h0D) then LF (8'h0A); 0 = EOL is LF only.

Ports:
- clock  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_data  in  8  payload byte from upstream.
- s_valid  in  1  s_data is valid.
- s_last  in  1  qualifies s_data as the final byte of a block.
- s_ready  out  1  block accepts s_data this cycle.
- m_data  out  8  byte toward the uart tx interface (tx.data).
- m_valid  out  1  m_data is valid (tx.valid).
- m_ready  in  1  uart tx accepts m_data (tx.ready).
- frame_done  out  1  one-cycle pulse when the EOL following an s_last byte is accepted downstream.
- col  out  8  current column (payload bytes emitted on the current line).

Behaviour:
- Reset (reset=1 at a clock edge, regardless of state, including mid-line or mid-EOL):
  - m_valid=0, m_data=8'h00, frame_done=0, col=0, state=PASS.
  - No partial EOL is completed after reset.
- Handshake rules:
  - Transfer occurs on an edge where valid&&ready.
  - m_data/m_valid are registers. While m_valid=1 && m_ready=0, m_data must hold stable.
  - Output register is "free" when !m_valid || m_ready.
- States: PASS, EOL_CR, EOL_LF.
- PASS:
  - s_ready = free (combinational from m_valid/m_ready/state); s_ready=0 in all other states.
  - On s_valid&&s_ready: m_data<=s_data, m_valid<=1.
  - If s_last or col==LINE_LEN-1: col<=0, latch last_flag<=s_last, state<=(EOL_CRLF ? EOL_CR : EOL_LF).
  - Otherwise col<=col+1.
  - If free and no acceptance: m_valid<=0.
- EOL_CR: when free, m_data<=8'h0D, m_valid<=1, state<=EOL_LF.
- EOL_LF: when free, m_data<=8'h0A, m_valid<=1, state<=PASS.
- frame_done:
  - Asserted for exactly one cycle: the cycle after the LF transfer (m_valid&&m_ready with m_data=LF) of a line whose last_flag=1.
  - last_flag is cleared at that point.
- Latency and throughput:
  - Payload byte appears on m_data one clock after acceptance.
  - Full throughput of 1 byte/cycle inside a line with m_ready held high.
  - Each EOL costs 1 (LF only) or 2 (CRLF) bubble cycles on s_ready.
- Boundary conditions:
  - s_last coinciding with col==LINE_LEN-1: a single EOL is emitted, never two.
  - LINE_LEN=1: EOL after every byte.
  - s_last on the first byte of a line: a one-byte line, then EOL.
  - m_ready stuck low: everything stalls. s_ready=0, state frozen, m_data stable.
  - Payload bytes equal to 8'h0D/8'h0A: passed through verbatim; they do not reset col.
  - col never exceeds LINE_LEN-1 when observed.

Decomposition:
- Shared package uart_pkg:
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A constants.
  - framer_state_t enum {PASS, EOL_CR, EOL_LF}.
- No sub-module. The output register and FSM are a single always_ff block plus a small comb block for s_ready/free.

Test Plan:
- LINE_LEN=4, EOL_CRLF=1, m_ready=1, send 8'h41..8'h48 with s_last on 8'h48 -> m stream 41 42 43 44 0D 0A 45 46 47 48 0D 0A; frame_done pulses once, after the final 0A; s_ready low 2 cycles after the 44 and 48 accepts.
- LINE_LEN=16, EOL_CRLF=0, send 3 bytes 8'h31,8'h32,8'h33 with s_last on 8'h33 -> 31 32 33 0A; col returns to 0; frame_done=1 for one cycle.
- Backpressure: m_ready toggles 1010… while streaming 36 bytes (LINE_LEN=16, last on byte 36) -> no byte lost or duplicated; m_data stable during every m_ready=0 cycle; output = 16 B + CRLF + 16 B + CRLF + 4 B + CRLF.
- Payload containing 8'h0D,8'h0A mid-line (LINE_LEN=4): 0D 0A 41 42 -> output 0D 0A 41 42 0D 0A (verbatim plus one EOL).
- Reset while in EOL_CR with m_valid=1, m_ready=0 -> next cycle m_valid=0, s_ready=1, col=0; subsequent byte 8'h55 emitted alone, with no stray 0D/0A.
- LINE_LEN=1, 3 bytes, last on third -> b0 0D 0A b1 0D 0A b2 0D 0A; frame_done once.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: ASCII line-control bytes
// and the state encoding of the line framer.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        PASS,
        EOL_CR,
        EOL_LF
    } framer_state_t;

endpackage

// File: rtl/tx_line_framer.sv
// Line framer ahead of the UART transmitter: forwards payload bytes and inserts
// an end-of-line sequence after every LINE_LEN bytes or after a block's last byte.
module tx_line_framer
    import uart_pkg::*;
#(
    parameter int LINE_LEN = 16,
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_done,
    output logic [7:0] col
);

    localparam logic [7:0]    LAST_COL  = 8'(LINE_LEN - 1);
    localparam framer_state_t EOL_START = EOL_CRLF ? EOL_CR : EOL_LF;

    framer_state_t state;
    logic          free;
    logic          last_flag;
    // Set only when the output register holds the LF of an inserted EOL, so a
    // payload 8'h0A can never be mistaken for the end of a frame.
    logic          eol_lf_held;

    // NOTE: every signal driven in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        free    = !m_valid || m_ready;
        s_ready = 1'b0;
        if (state == PASS) begin
            s_ready = free;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= PASS;
            m_data      <= 8'h00;
            m_valid     <= 1'b0;
            frame_done  <= 1'b0;
            col         <= 8'h00;
            last_flag   <= 1'b0;
            eol_lf_held <= 1'b0;
        end else begin
            frame_done <= m_valid && m_ready && eol_lf_held && last_flag;
            if (m_valid && m_ready && eol_lf_held) begin
                last_flag <= 1'b0;
            end

            unique case (state)
                PASS: begin
                    if (s_valid && s_ready) begin
                        m_data      <= s_data;
                        m_valid     <= 1'b1;
                        eol_lf_held <= 1'b0;
                        if (s_last || col == LAST_COL) begin
                            col       <= 8'h00;
                            last_flag <= s_last;
                            state     <= EOL_START;
                        end else begin
                            col <= col + 8'd1;
                        end
                    end else if (free) begin
                        m_valid <= 1'b0;
                    end
                end
                EOL_CR: begin
                    if (free) begin
                        m_data      <= ASCII_CR;
                        m_valid     <= 1'b1;
                        eol_lf_held <= 1'b0;
                        state       <= EOL_LF;
                    end
                end
                EOL_LF: begin
                    if (free) begin
                        m_data      <= ASCII_LF;
                        m_valid     <= 1'b1;
                        eol_lf_held <= 1'b1;
                        state       <= PASS;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_line_framer.sv
// Scoreboard bench for tx_line_framer: four parameterisations share one clock;
// expected bytes are queued by the stimulus and consumed by an output monitor.
module tb_tx_line_framer;

    typedef struct {
        int         d;
        logic [7:0] data;
        bit         fin;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_data  [4];
    logic       s_valid [4];
    logic       s_last  [4];
    logic       s_ready [4];
    logic [7:0] m_data  [4];
    logic       m_valid [4];
    logic       m_ready_w [4];
    logic       frame_done [4];
    logic [7:0] col     [4];

    logic [3:0] bp_en   = 4'b0000;
    logic [3:0] rdy_lvl = 4'b1111;
    logic       tog     = 1'b0;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clock = ~clock;
    always @(posedge clock) tog <= ~tog;

    assign m_ready_w[0] = bp_en[0] ? tog : rdy_lvl[0];
    assign m_ready_w[1] = bp_en[1] ? tog : rdy_lvl[1];
    assign m_ready_w[2] = bp_en[2] ? tog : rdy_lvl[2];
    assign m_ready_w[3] = bp_en[3] ? tog : rdy_lvl[3];

    tx_line_framer #(.LINE_LEN(4), .EOL_CRLF(1'b1)) u_dut0 (
        .clock(clock), .reset(reset),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]), .s_ready(s_ready[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready_w[0]),
        .frame_done(frame_done[0]), .col(col[0])
    );
    tx_line_framer #(.LINE_LEN(16), .EOL_CRLF(1'b0)) u_dut1 (
        .clock(clock), .reset(reset),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]), .s_ready(s_ready[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready_w[1]),
        .frame_done(frame_done[1]), .col(col[1])
    );
    tx_line_framer #(.LINE_LEN(16), .EOL_CRLF(1'b1)) u_dut2 (
        .clock(clock), .reset(reset),
        .s_data(s_data[2]), .s_valid(s_valid[2]), .s_last(s_last[2]), .s_ready(s_ready[2]),
        .m_data(m_data[2]), .m_valid(m_valid[2]), .m_ready(m_ready_w[2]),
        .frame_done(frame_done[2]), .col(col[2])
    );
    tx_line_framer #(.LINE_LEN(1), .EOL_CRLF(1'b1)) u_dut3 (
        .clock(clock), .reset(reset),
        .s_data(s_data[3]), .s_valid(s_valid[3]), .s_last(s_last[3]), .s_ready(s_ready[3]),
        .m_data(m_data[3]), .m_valid(m_valid[3]), .m_ready(m_ready_w[3]),
        .frame_done(frame_done[3]), .col(col[3])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [7:0] data, input bit fin);
        exp_t e;
        e.d    = d;
        e.data = data;
        e.fin  = fin;
        exp_q.push_back(e);
    endtask

    // Offers one byte and returns once it has been accepted; waits counts
    // the negedges on which s_ready was low.
    task automatic send(input int d, input logic [7:0] data, input logic last, output int waits);
        s_data[d]  = data;
        s_last[d]  = last;
        s_valid[d] = 1'b1;
        waits      = 0;
        forever begin
            @(negedge clock);
            if (s_ready[d]) begin
                @(posedge clock);
                #1;
                break;
            end
            waits++;
            if (waits > 500) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout dev %0d: s_ready stayed 0, expected 1", d);
                break;
            end
        end
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        repeat (4) @(negedge clock);
        check(name, exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every transfer, checks the
    // frame_done pulse timing and output stability under backpressure.
    initial begin
        exp_t       e;
        bit         fd_exp     [4];
        bit         stall_prev [4];
        logic [7:0] hold_data  [4];
        for (int d = 0; d < 4; d++) begin
            fd_exp[d]     = 1'b0;
            stall_prev[d] = 1'b0;
            hold_data[d]  = 8'h00;
        end
        forever begin
            @(negedge clock);
            for (int d = 0; d < 4; d++) begin
                if (reset) begin
                    fd_exp[d]     = 1'b0;
                    stall_prev[d] = 1'b0;
                end else begin
                    if (fd_exp[d] || frame_done[d] !== 1'b0) begin
                        check($sformatf("frame_done_dev%0d", d), 32'(frame_done[d]), 32'(fd_exp[d]));
                    end
                    fd_exp[d] = 1'b0;
                    if (stall_prev[d]) begin
                        check($sformatf("hold_valid_dev%0d", d), 32'(m_valid[d]), 32'd1);
                        check($sformatf("hold_data_dev%0d", d), 32'(m_data[d]), 32'(hold_data[d]));
                    end
                    stall_prev[d] = m_valid[d] && !m_ready_w[d];
                    hold_data[d]  = m_data[d];
                    if (m_valid[d] && m_ready_w[d]) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_out dev %0d: got byte %0h, expected no output", d, m_data[d]);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_dev", d, e.d);
                            check($sformatf("out_data_dev%0d", d), 32'(m_data[d]), 32'(e.data));
                            fd_exp[d] = e.fin;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int w;
        for (int d = 0; d < 4; d++) begin
            s_data[d]  = 8'h00;
            s_valid[d] = 1'b0;
            s_last[d]  = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst_m_valid_dev%0d", d), 32'(m_valid[d]), 32'd0);
            check($sformatf("rst_m_data_dev%0d", d), 32'(m_data[d]), 32'h00);
            check($sformatf("rst_col_dev%0d", d), 32'(col[d]), 32'd0);
            check($sformatf("rst_frame_done_dev%0d", d), 32'(frame_done[d]), 32'd0);
            check($sformatf("rst_s_ready_dev%0d", d), 32'(s_ready[d]), 32'd1);
        end
        @(posedge clock);
        #1 reset = 1'b0;

        // LINE_LEN=4, CRLF: two lines, last on the eighth byte.
        for (int k = 0; k < 4; k++) push(0, 8'h41 + 8'(k), 1'b0);
        push(0, 8'h0D, 1'b0);
        push(0, 8'h0A, 1'b0);
        for (int k = 4; k < 8; k++) push(0, 8'h41 + 8'(k), 1'b0);
        push(0, 8'h0D, 1'b0);
        push(0, 8'h0A, 1'b1);
        for (int k = 0; k < 8; k++) begin
            send(0, 8'h41 + 8'(k), k == 7, w);
            if (k == 4) check("bubble_after_44", w, 2);
        end
        @(negedge clock);
        check("s_ready_after_48_c1", 32'(s_ready[0]), 32'd0);
        @(negedge clock);
        check("s_ready_after_48_c2", 32'(s_ready[0]), 32'd0);
        @(negedge clock);
        check("s_ready_after_48_c3", 32'(s_ready[0]), 32'd1);
        drain("drain_t1");
        check("col_t1", 32'(col[0]), 32'd0);

        // LINE_LEN=16, LF only: short block.
        push(1, 8'h31, 1'b0);
        push(1, 8'h32, 1'b0);
        push(1, 8'h33, 1'b0);
        push(1, 8'h0A, 1'b1);
        send(1, 8'h31, 1'b0, w);
        send(1, 8'h32, 1'b0, w);
        check("col_t2_mid", 32'(col[1]), 32'd2);
        send(1, 8'h33, 1'b1, w);
        drain("drain_t2");
        check("col_t2", 32'(col[1]), 32'd0);

        // LINE_LEN=16, CRLF, m_ready toggling: 36 bytes, last on byte 36.
        bp_en[2] = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            push(2, 8'(k), 1'b0);
            if (k == 16 || k == 32 || k == 36) begin
                push(2, 8'h0D, 1'b0);
                push(2, 8'h0A, k == 36);
            end
        end
        for (int k = 1; k <= 36; k++) send(2, 8'(k), k == 36, w);
        drain("drain_t3");
        bp_en[2] = 1'b0;
        check("col_t3", 32'(col[2]), 32'd0);

        // Payload CR/LF bytes pass through and still count as columns.
        push(0, 8'h0D, 1'b0);
        push(0, 8'h0A, 1'b0);
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h0D, 1'b0);
        push(0, 8'h0A, 1'b0);
        send(0, 8'h0D, 1'b0, w);
        send(0, 8'h0A, 1'b0, w);
        send(0, 8'h41, 1'b0, w);
        check("col_t4_mid", 32'(col[0]), 32'd3);
        send(0, 8'h42, 1'b0, w);
        drain("drain_t4");
        check("col_t4", 32'(col[0]), 32'd0);

        // Reset while parked in EOL_CR with the output stalled.
        rdy_lvl[0] = 1'b0;
        send(0, 8'h77, 1'b1, w);
        @(negedge clock);
        check("stall_s_ready", 32'(s_ready[0]), 32'd0);
        check("stall_m_valid", 32'(m_valid[0]), 32'd1);
        check("stall_m_data", 32'(m_data[0]), 32'h77);
        repeat (3) @(negedge clock);
        check("stall_col", 32'(col[0]), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("post_rst_m_valid", 32'(m_valid[0]), 32'd0);
        check("post_rst_s_ready", 32'(s_ready[0]), 32'd1);
        check("post_rst_col", 32'(col[0]), 32'd0);
        rdy_lvl[0] = 1'b1;
        @(posedge clock);
        #1;
        push(0, 8'h55, 1'b0);
        send(0, 8'h55, 1'b0, w);
        drain("drain_t5");
        check("col_t5", 32'(col[0]), 32'd1);

        // LINE_LEN=1: EOL after every byte.
        for (int k = 0; k < 3; k++) begin
            push(3, 8'h61 + 8'(k), 1'b0);
            push(3, 8'h0D, 1'b0);
            push(3, 8'h0A, k == 2);
        end
        for (int k = 0; k < 3; k++) begin
            send(3, 8'h61 + 8'(k), k == 2, w);
            check($sformatf("col_t6_%0d", k), 32'(col[3]), 32'd0);
        end
        drain("drain_t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
